// File: rtl/xb_result_collector.sv
// xb_result_collector
//   Collects the six 16-bit results that each wavelet filter lane delivers
//   with its lane_finish pulse, keeps them in a per-lane holding slot, and
//   serialises the slots round-robin as 6-word frames on one valid/ready
//   stream that feeds the DDR write FIFO.
//
// Ports
//   phy_clk_0    in   sole clock, rising edge
//   reset        in   asynchronous, active-low
//   lane_data    in   lane i at [i*6*DW +: 6*DW], word k at [k*DW +: DW]
//   lane_finish  in   1-cycle pulse per lane, lane_data valid in that cycle
//   out_data     out  current frame word (registered)
//   out_valid    out  out_data valid
//   out_ready    in   sink accepts when out_valid && out_ready
//   out_sop      out  high with word 0 of a frame
//   out_eop      out  high with word 5 of a frame
//   out_lane     out  source lane of the current frame
//   pending      out  slot i holds an unsent frame
//   overrun      out  sticky: lane i finished while its slot was pending
//
// Build option XB_COLLECT_STAT_EN adds two wrapping 16-bit counters:
//   frame_cnt    out  accepted eop words
//   drop_cnt     out  lane results dropped by overrun (summed per cycle)
module xb_result_collector #(
  parameter int NUM_LANE = 8,
  parameter int LANE_W   = 3,
  parameter int DW       = 16
) (
  input  logic                     phy_clk_0,
  input  logic                     reset,
  input  logic [NUM_LANE*6*DW-1:0] lane_data,
  input  logic [NUM_LANE-1:0]      lane_finish,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [LANE_W-1:0]        out_lane,
  output logic [NUM_LANE-1:0]      pending,
  output logic [NUM_LANE-1:0]      overrun
`ifdef XB_COLLECT_STAT_EN
  ,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [DW-1:0]       slot [NUM_LANE][6];
  logic [2:0]          w;
  logic [LANE_W-1:0]   rr_ptr;
  logic [LANE_W-1:0]   grant;
  logic                grant_vld;
  logic                accept;
  logic                eop_acc;
  logic [NUM_LANE-1:0] completing;
  logic [NUM_LANE-1:0] capture;
  logic [NUM_LANE-1:0] drop;

  // First pending lane at or after rr_ptr; the LANE_W-bit add wraps modulo NUM_LANE.
  always_comb begin
    grant     = rr_ptr;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      if (!grant_vld && pending[rr_ptr + LANE_W'(i)]) begin
        grant     = rr_ptr + LANE_W'(i);
        grant_vld = 1'b1;
      end
    end
  end

  // A slot whose eop word is accepted this edge is free again, so a finish
  // arriving on that same edge is captured rather than counted as an overrun.
  always_comb begin
    accept     = out_valid && out_ready;
    eop_acc    = (state == SEND) && accept && (w == 3'd5);
    completing = '0;
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      completing[i] = eop_acc && (out_lane == LANE_W'(i));
    end
    capture = lane_finish & (~pending | completing);
    drop    = lane_finish & pending & ~completing;
  end

  always_ff @(posedge phy_clk_0 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = SEND;
      SEND:    if (eop_acc)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot contents need no reset: pending is cleared on reset, which discards them.
  always_ff @(posedge phy_clk_0) begin
    for (int unsigned i = 0; i < NUM_LANE; i++) begin
      if (capture[i]) begin
        for (int unsigned k = 0; k < 6; k++) begin
          slot[i][k] <= lane_data[(i*6 + k)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge phy_clk_0 or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_lane  <= '0;
      w         <= '0;
      rr_ptr    <= '0;
      pending   <= '0;
      overrun   <= '0;
    end else begin
      pending <= (pending & ~completing) | capture;
      overrun <= overrun | drop;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            out_lane  <= grant;
            w         <= '0;
            out_valid <= 1'b1;
            out_sop   <= 1'b1;
            out_eop   <= 1'b0;
            out_data  <= slot[grant][0];
          end
        end
        SEND: begin
          if (accept) begin
            if (w < 3'd5) begin
              w        <= w + 3'd1;
              out_sop  <= 1'b0;
              out_eop  <= (w == 3'd4);
              out_data <= slot[out_lane][w + 3'd1];
            end else begin
              out_valid <= 1'b0;
              out_eop   <= 1'b0;
              rr_ptr    <= out_lane + LANE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef XB_COLLECT_STAT_EN
  always_ff @(posedge phy_clk_0 or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      frame_cnt <= frame_cnt + {15'd0, eop_acc};
      drop_cnt  <= drop_cnt + 16'($countones(drop));
    end
  end
`endif

endmodule

// File: tb/tb_xb_result_collector.sv
// tb_xb_result_collector
//   Bench for xb_result_collector. Captured lane results are pushed into
//   per-lane expected-frame queues by a frame-level reference model; a monitor
//   pops a frame when the DUT starts one and compares every presented word,
//   the framing flags, the granted lane, pending and overrun.
//   Define XB_COLLECT_STAT_EN to also check the statistics counters.
module tb_xb_result_collector;
  localparam int NUM_LANE = 8;
  localparam int LANE_W   = 3;
  localparam int DW       = 16;

  logic                     phy_clk_0 = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_LANE*6*DW-1:0] lane_data = '0;
  logic [NUM_LANE-1:0]      lane_finish = '0;
  logic [DW-1:0]            out_data;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic                     out_sop;
  logic                     out_eop;
  logic [LANE_W-1:0]        out_lane;
  logic [NUM_LANE-1:0]      pending;
  logic [NUM_LANE-1:0]      overrun;
`ifdef XB_COLLECT_STAT_EN
  logic [15:0]              frame_cnt;
  logic [15:0]              drop_cnt;
`endif

  xb_result_collector #(.NUM_LANE(NUM_LANE), .LANE_W(LANE_W), .DW(DW)) dut (
    .phy_clk_0  (phy_clk_0),
    .reset      (reset),
    .lane_data  (lane_data),
    .lane_finish(lane_finish),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_lane   (out_lane),
    .pending    (pending),
    .overrun    (overrun)
`ifdef XB_COLLECT_STAT_EN
    ,
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 phy_clk_0 = ~phy_clk_0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge phy_clk_0) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state (frame level).
  logic [6*DW-1:0]     exp_q [NUM_LANE][$];
  logic [NUM_LANE-1:0] m_pending = '0;
  logic [NUM_LANE-1:0] m_overrun = '0;
  logic [NUM_LANE-1:0] snap_pending = '0;
  int                  m_rr = 0, snap_rr = 0;
  bit                  in_frame = 0, busy_snap = 0;
  int                  m_idx = 0, m_lane = 0;
  logic [6*DW-1:0]     m_frame = '0;
  int                  m_frames = 0, m_drops = 0;
  int                  first_valid_cyc = -1, last_eop_cyc = -1;
  int                  sop_lanes[$];

  function automatic int first_pending(input logic [NUM_LANE-1:0] p, input int rr);
    for (int i = 0; i < NUM_LANE; i++)
      if (p[(rr + i) % NUM_LANE]) return (rr + i) % NUM_LANE;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_LANE; i++) exp_q[i].delete();
    m_pending = '0; m_overrun = '0; snap_pending = '0;
    m_rr = 0; snap_rr = 0; in_frame = 0; busy_snap = 0;
    m_idx = 0; m_frames = 0; m_drops = 0;
  endtask

  // Monitor + model: at each falling edge the outputs for the current cycle and the
  // inputs for the coming rising edge are stable, so the model is advanced here.
  always @(negedge phy_clk_0) begin : mon
    logic [NUM_LANE-1:0] prev_snap;
    int  prev_rr, exp_lane, done_lane;
    bit  prev_busy;
    if (reset) begin
      prev_snap = snap_pending; prev_rr = snap_rr; prev_busy = busy_snap;
      snap_pending = m_pending; snap_rr = m_rr; busy_snap = in_frame;
      chk("pending", pending, m_pending);
      chk("overrun", overrun, m_overrun);
`ifdef XB_COLLECT_STAT_EN
      chk("frame_cnt", frame_cnt, 16'(m_frames));
      chk("drop_cnt", drop_cnt, 16'(m_drops));
`endif
      done_lane = -1;
      if (out_valid) begin
        if (!in_frame) begin
          exp_lane = first_pending(prev_snap, prev_rr);
          if (prev_busy || exp_lane < 0) begin
            chk("unexpected_frame", 1, 0);
            exp_lane = int'(out_lane);
          end else begin
            chk("grant_lane", out_lane, exp_lane);
          end
          m_lane = exp_lane;
          if (exp_q[m_lane].size() == 0) begin
            chk("frame_without_capture", 1, 0);
            m_frame = '0;
          end else begin
            m_frame = exp_q[m_lane].pop_front();
          end
          in_frame = 1; m_idx = 0;
          sop_lanes.push_back(int'(out_lane));
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        chk("out_data", out_data, m_frame[m_idx*DW +: DW]);
        chk("out_sop", out_sop, m_idx == 0);
        chk("out_eop", out_eop, m_idx == 5);
        chk("out_lane_stable", out_lane, m_lane);
        if (out_ready) begin
          m_idx++;
          if (m_idx == 6) begin
            in_frame = 0; done_lane = m_lane; m_frames++; last_eop_cyc = cyc;
          end
        end
      end else begin
        if (in_frame) chk("valid_dropped_midframe", 0, 1);
        else if (!prev_busy && prev_snap != '0) chk("missed_grant", 0, 1);
      end
      for (int i = 0; i < NUM_LANE; i++) begin
        if (lane_finish[i]) begin
          if (!m_pending[i] || done_lane == i) begin
            exp_q[i].push_back(lane_data[i*6*DW +: 6*DW]);
            m_pending[i] = 1'b1;
          end else begin
            m_overrun[i] = 1'b1;
            m_drops++;
          end
        end
      end
      if (done_lane >= 0) begin
        if (!lane_finish[done_lane]) m_pending[done_lane] = 1'b0;
        m_rr = (done_lane + 1) % NUM_LANE;
      end
    end
  end

  task automatic step();
    @(posedge phy_clk_0);
    #2;
  endtask

  task automatic pulse(input logic [NUM_LANE-1:0] mask);
    for (int i = 0; i < NUM_LANE; i++)
      if (mask[i]) lane_data[i*6*DW +: 6*DW] = {$urandom, $urandom, $urandom};
    lane_finish = mask;
    step();
    lane_finish = '0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((m_pending != '0 || in_frame || out_valid) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sop"}, out_sop, 0);
    chk({tag, "_out_eop"}, out_eop, 0);
    chk({tag, "_out_lane"}, out_lane, 0);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int vcnt, fin_cyc, g;
    // Reset state
    reset = 1'b0;
    model_clear();
    repeat (3) step();
    check_all_zero("reset");
`ifdef XB_COLLECT_STAT_EN
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
`endif
    reset = 1'b1;
    step();

    // T2: all lanes at once, from rr_ptr=0
    out_ready = 1'b1;
    first_valid_cyc = -1; sop_lanes.delete();
    pulse('1);
    wait_drain(200);
    chk("t2_frame_count", sop_lanes.size(), 8);
    for (int i = 0; i < NUM_LANE; i++)
      if (i < sop_lanes.size()) chk("t2_lane_order", sop_lanes[i], i);
    chk("t2_span", last_eop_cyc - first_valid_cyc, 54);
    chk("t2_pending_clear", pending, 0);

    // T1: single lane 3 with fixed words
    first_valid_cyc = -1; sop_lanes.delete();
    for (int k = 0; k < 6; k++) lane_data[(3*6 + k)*DW +: DW] = 16'(16'h0101 + k);
    lane_finish = 8'h08;
    step();
    lane_finish = '0;
    fin_cyc = cyc;
    wait_drain(50);
    chk("t1_latency", first_valid_cyc - fin_cyc, 1);
    chk("t1_frame_len", last_eop_cyc - first_valid_cyc, 5);
    chk("t1_frames", sop_lanes.size(), 1);
    if (sop_lanes.size() > 0) chk("t1_lane", sop_lanes[0], 3);
    chk("t1_pending_clear", pending, 0);

    // T3: backpressure on a lane-5 frame, ready 0,1,0,1... from the first valid cycle
    out_ready = 1'b0;
    pulse(8'h20);
    g = 0;
    while (!out_valid && g < 10) begin step(); g++; end
    vcnt = 0;
    while (out_valid && vcnt < 40) begin
      vcnt++;
      step();
      out_ready = ~out_ready;
    end
    chk("t3_cycles", vcnt, 12);
    out_ready = 1'b1;
    wait_drain(50);

    // T4: overrun on lane 2 while held off
    out_ready = 1'b0;
    pulse(8'h04);
    repeat (2) step();
    pulse(8'h04);
    step();
    chk("t4_overrun", overrun[2], 1);
    out_ready = 1'b1;
    wait_drain(50);
`ifdef XB_COLLECT_STAT_EN
    chk("t4_drop_cnt", drop_cnt, 1);
`endif

    // T5: new lane-6 results on the edge its eop word is accepted
    pulse(8'h40);
    repeat (6) step();
    chk("t5_eop_align", {out_valid, out_eop, out_lane}, {1'b1, 1'b1, 3'd6});
    lane_data[6*6*DW +: 6*DW] = {$urandom, $urandom, $urandom};
    lane_finish = 8'h40;
    step();
    lane_finish = '0;
    step();
    chk("t5_no_overrun", overrun[6], 0);
    chk("t5_pending_kept", pending[6], 1);
    wait_drain(50);

    // T6: reset during word 2 of a frame
    pulse(8'h12);
    repeat (3) step();
    chk("t6_word2_present", {out_valid, out_sop, out_lane}, {1'b1, 1'b0, 3'd1});
    reset = 1'b0;
    model_clear();
    #1;
    check_all_zero("t6_async");
    repeat (2) step();
    reset = 1'b1;
    repeat (5) step();
    chk("t6_idle_valid", out_valid, 0);
    chk("t6_idle_pending", pending, 0);
    sop_lanes.delete();
    pulse(8'h24);
    wait_drain(50);
    if (sop_lanes.size() > 0) chk("t6_rr_restart", sop_lanes[0], 2);
    chk("t6_frames", sop_lanes.size(), 2);

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) pulse(NUM_LANE'($urandom));
      else step();
    end
    out_ready = 1'b1;
    wait_drain(500);
    for (int i = 0; i < NUM_LANE; i++) chk("final_queue_empty", exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
